// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: RV32I opcodes,
// descriptor kind codes, loader FSM states and the descriptor payload struct.
package inst_mem_loader_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned KIND_W = 3;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 7;

  // RV32I major opcodes
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] ECALL_WORD = 32'h0000_0073;

  // Descriptor kinds as presented on in_kind
  typedef enum logic [KIND_W-1:0] {
    KIND_R       = 3'd0,
    KIND_I_ARITH = 3'd1,
    KIND_LOAD    = 3'd2,
    KIND_JALR    = 3'd3,
    KIND_STORE   = 3'd4,
    KIND_BRANCH  = 3'd5,
    KIND_JAL     = 3'd6,
    KIND_ECALL   = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Instruction descriptor as handed to the encoder
  typedef struct packed {
    kind_e             kind;
    logic [F3_W-1:0]   funct3;
    logic              alt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN-1:0]   imm;
  } desc_t;

  // Assemble an I-format word from its fields
  function automatic logic [XLEN-1:0] i_format(input logic [11:0]      imm12,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [F3_W-1:0]  f3,
                                               input logic [REG_W-1:0] rd,
                                               input logic [OP_W-1:0]  op);
    return {imm12, rs1, f3, rd, op};
  endfunction

endpackage

// File: rtl/inst_mem_loader_encoder.sv
// Combinational RV32I encoder: descriptor in, 32-bit instruction word out,
// plus a flag for control-transfer offsets that are not 2-byte aligned.
module rv32i_inst_encoder
  import inst_mem_loader_pkg::*;
(
  input  desc_t           i_desc,
  output logic [XLEN-1:0] o_word,
  output logic            o_align_bad
);

  logic [11:0] w_imm12;
  logic        w_unused_imm;

  // Upper immediate bits never reach any format
  assign w_unused_imm = ^i_desc.imm[XLEN-1:21];

  // Format selection by descriptor kind
  always_comb begin
    o_word      = '0;
    o_align_bad = 1'b0;
    w_imm12     = i_desc.imm[11:0];
    unique case (i_desc.kind)
      KIND_R: begin
        o_word = {1'b0, i_desc.alt, 5'b0, i_desc.rs2, i_desc.rs1,
                  i_desc.funct3, i_desc.rd, OP_R};
      end
      KIND_I_ARITH: begin
        // Shifts carry only a 5-bit shamt; imm[10] selects SRAI
        if (i_desc.funct3 == 3'b001 || i_desc.funct3 == 3'b101) begin
          w_imm12 = {1'b0, i_desc.alt, 5'b0, i_desc.imm[4:0]};
        end
        o_word = i_format(w_imm12, i_desc.rs1, i_desc.funct3, i_desc.rd, OP_I);
      end
      KIND_LOAD: begin
        o_word = i_format(w_imm12, i_desc.rs1, i_desc.funct3, i_desc.rd, OP_LOAD);
      end
      KIND_JALR: begin
        o_word = i_format(w_imm12, i_desc.rs1, i_desc.funct3, i_desc.rd, OP_JALR);
      end
      KIND_STORE: begin
        o_word = {i_desc.imm[11:5], i_desc.rs2, i_desc.rs1, i_desc.funct3,
                  i_desc.imm[4:0], OP_STORE};
      end
      KIND_BRANCH: begin
        o_word = {i_desc.imm[12], i_desc.imm[10:5], i_desc.rs2, i_desc.rs1,
                  i_desc.funct3, i_desc.imm[4:1], i_desc.imm[11], OP_BRANCH};
        o_align_bad = i_desc.imm[0];
      end
      KIND_JAL: begin
        o_word = {i_desc.imm[20], i_desc.imm[10:1], i_desc.imm[11],
                  i_desc.imm[19:12], i_desc.rd, OP_JAL};
        o_align_bad = i_desc.imm[0];
      end
      KIND_ECALL: begin
        o_word = ECALL_WORD;
      end
      default: begin
        o_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: accepts descriptors, encodes them to RV32I words
// and writes them to consecutive word addresses, with done/overflow/align status.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KIND_W-1:0]     in_kind,
  input  logic [F3_W-1:0]       in_funct3,
  input  logic                  in_alt,
  input  logic [REG_W-1:0]      in_rd,
  input  logic [REG_W-1:0]      in_rs1,
  input  logic [REG_W-1:0]      in_rs2,
  input  logic [XLEN-1:0]       in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [ADDR_WIDTH:0]   inst_count,
  output logic                  done,
  output logic                  overflow_err,
  output logic                  align_err
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e                r_state, w_state_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0]       r_mem_wdata, w_mem_wdata_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_align, w_align_nxt;
  logic                  w_in_ready;

  desc_t                 w_desc;
  logic [XLEN-1:0]       w_word;
  logic                  w_align_bad;
  logic                  w_full;

  // Pack handshake fields into a descriptor for the encoder
  always_comb begin
    w_desc        = '0;
    w_desc.kind   = kind_e'(in_kind);
    w_desc.funct3 = in_funct3;
    w_desc.alt    = in_alt;
    w_desc.rd     = in_rd;
    w_desc.rs1    = in_rs1;
    w_desc.rs2    = in_rs2;
    w_desc.imm    = in_imm;
  end

  rv32i_inst_encoder u_encoder (
    .i_desc      (w_desc),
    .o_word      (w_word),
    .o_align_bad (w_align_bad)
  );

  assign w_full = (r_count == DEPTH_C);

  // Next-state, handshake and memory-port logic
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_count_nxt     = r_count;
    w_done_nxt      = r_done;
    w_ovf_nxt       = r_ovf;
    w_align_nxt     = r_align;
    w_in_ready      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_align_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        // start wins over a descriptor offered in the same cycle
        w_in_ready = ~start;
        if (start) begin
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_align_nxt = 1'b0;
        end else if (in_valid) begin
          if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = r_count[ADDR_WIDTH-1:0];
            w_mem_wdata_nxt = w_word;
            w_count_nxt     = r_count + CNT_W'(1);
          end
          if (w_align_bad) begin
            w_align_nxt = 1'b1;
          end
          if (w_desc.kind == KIND_ECALL) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
          w_done_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_align_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_align     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_ovf       <= w_ovf_nxt;
      r_align     <= w_align_nxt;
    end
  end

  assign in_ready     = w_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign inst_count   = r_count;
  assign done         = r_done;
  assign overflow_err = r_ovf;
  assign align_err    = r_align;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed vector table, randomized
// stream against a reference encoder, and multi-cycle corner sequences.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        s_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, mem_we, done, overflow_err, align_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] inst_count;

  logic        s_in_ready, s_mem_we, s_done, s_overflow_err, s_align_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_inst_count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_mem_loader #(.ADDR_WIDTH(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .inst_count(inst_count), .done(done),
    .overflow_err(overflow_err), .align_err(align_err)
  );

  inst_mem_loader #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .inst_count(s_inst_count), .done(s_done),
    .overflow_err(s_overflow_err), .align_err(s_align_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] k, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_kind = k; in_funct3 = f3; in_alt = alt;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Reference encoder built from field positions with shifts and masks
  function automatic logic [31:0] ref_encode(input logic [2:0] k, input logic [2:0] f3,
                                             input logic alt, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] regs_i, regs_r, imm12, a;
    regs_i = (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
    regs_r = regs_i | (32'(rs2) << 20);
    imm12  = imm & 32'hFFF;
    a      = 32'(alt);
    case (k)
      3'd0: return 32'h33 | regs_r | (a << 30);
      3'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm12 = (a << 10) | (imm & 32'h1F);
        return 32'h13 | regs_i | (imm12 << 20);
      end
      3'd2: return 32'h03 | regs_i | (imm12 << 20);
      3'd3: return 32'h67 | regs_i | (imm12 << 20);
      3'd4: return 32'h23 | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                   | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
      3'd5: return 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                   | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd6: return 32'h6F | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 20) & 32'h1) << 31);
      default: return 32'h73;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic        exp_align;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic        exp_align;
    logic [10:0] exp_cnt;
    logic        v_prev;
    logic [31:0] w_prev;
    logic [2:0]  k;
    logic [31:0] imm;

    // Directed vectors with hand-assembled expected words
    vecs[0] = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b0};
    vecs[1] = '{3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF0_0293, 1'b0};
    vecs[2] = '{3'd4, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8,          32'h0051_2423, 1'b0};
    vecs[3] = '{3'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h4031_5093, 1'b0};
    vecs[4] = '{3'd2, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 32'hFFFF_FFFC,  32'hFFC1_2303, 1'b0};
    vecs[5] = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,          32'h0000_8067, 1'b0};
    vecs[6] = '{3'd5, 3'd1, 1'b0, 5'd0, 5'd1, 5'd0, 32'hFFFF_FFFC,  32'hFE00_9EE3, 1'b0};
    vecs[7] = '{3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3,          32'h0020_00EF, 1'b1};

    // Reset values
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(inst_count), 32'd0);
    check("rst_flags", 32'({done, overflow_err, align_err}), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // Enter LOAD
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("load_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back
    exp_align = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].kind, vecs[i].f3, vecs[i].alt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      in_valid = 1'b1;
      tick();
      exp_align = exp_align | vecs[i].exp_align;
      check($sformatf("vec%0d_we", i), 32'(mem_we), 32'd1);
      check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(i));
      check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_word);
      check($sformatf("vec%0d_count", i), 32'(inst_count), 32'(i + 1));
      check($sformatf("vec%0d_align", i), 32'(align_err), 32'(exp_align));
    end

    // start in the cycle after an accept: strobe already issued, state cleared
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clr_we", 32'(mem_we), 32'd0);
    check("start_clr_count", 32'(inst_count), 32'd0);
    check("start_clr_align", 32'(align_err), 32'd0);

    // start beats in_valid in the same cycle
    drive(3'd0, 3'd0, 1'b0, 5'd7, 5'd7, 5'd7, 32'd0);
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    check("prio_in_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("prio_no_we", 32'(mem_we), 32'd0);
    check("prio_count", 32'(inst_count), 32'd0);

    // Randomized stream against the reference encoder
    exp_cnt = '0;
    exp_align = 1'b0;
    for (int c = 0; c < 80; c++) begin
      v_prev = ($urandom_range(0, 3) != 0);
      k = 3'($urandom_range(0, 6));
      imm = $urandom();
      drive(k, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
      in_valid = v_prev;
      w_prev = ref_encode(in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
      tick();
      if (v_prev) begin
        check("rnd_we", 32'(mem_we), 32'd1);
        check("rnd_addr", 32'(mem_addr), 32'(exp_cnt));
        check("rnd_wdata", mem_wdata, w_prev);
        exp_cnt = exp_cnt + 11'd1;
        if ((k == 3'd5 || k == 3'd6) && imm[0]) exp_align = 1'b1;
      end else begin
        check("rnd_idle_we", 32'(mem_we), 32'd0);
      end
      check("rnd_count", 32'(inst_count), 32'(exp_cnt));
      check("rnd_align", 32'(align_err), 32'(exp_align));
    end

    // ECALL ends the load; later descriptors are ignored
    drive(3'd7, 3'd5, 1'b1, 5'd9, 5'd9, 5'd9, 32'h1234_5679);
    in_valid = 1'b1;
    tick();
    exp_cnt = exp_cnt + 11'd1;
    check("ecall_we", 32'(mem_we), 32'd1);
    check("ecall_wdata", mem_wdata, 32'h0000_0073);
    check("ecall_done", 32'(done), 32'd1);
    check("ecall_in_ready", 32'(in_ready), 32'd0);
    drive(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_no_we", 32'(mem_we), 32'd0);
      check("done_count_hold", 32'(inst_count), 32'(exp_cnt));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check("restart_we", 32'(mem_we), 32'd0);
    check("restart_count", 32'(inst_count), 32'd0);
    check("restart_flags", 32'({done, overflow_err, align_err}), 32'd0);

    // Small memory: four writes, fifth overflows, ECALL while full still finishes
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive(3'd0, 3'd0, 1'b0, 5'(j), 5'd1, 5'd2, 32'd0);
      in_valid = 1'b1;
      tick();
      if (j < 4) begin
        check("ovf_we", 32'(s_mem_we), 32'd1);
        check("ovf_addr", 32'(s_mem_addr), 32'(j));
        check("ovf_count", 32'(s_inst_count), 32'(j + 1));
        check("ovf_flag_low", 32'(s_overflow_err), 32'd0);
      end else begin
        check("ovf_full_we", 32'(s_mem_we), 32'd0);
        check("ovf_full_count", 32'(s_inst_count), 32'd4);
        check("ovf_full_flag", 32'(s_overflow_err), 32'd1);
      end
    end
    drive(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    check("ovf_ecall_done", 32'(s_done), 32'd1);
    check("ovf_ecall_we", 32'(s_mem_we), 32'd0);
    check("ovf_sticky", 32'(s_overflow_err), 32'd1);

    // Reset in the write cycle after an accept
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rmw_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rmw_we", 32'(mem_we), 32'd0);
    check("rmw_addr", 32'(mem_addr), 32'd0);
    check("rmw_wdata", mem_wdata, 32'd0);
    check("rmw_count", 32'(inst_count), 32'd0);
    check("rmw_flags", 32'({done, overflow_err, align_err}), 32'd0);
    check("rmw_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
